// File: rtl/sub_shift_stage.sv
// sub_shift_stage: iterative AES SubBytes + ShiftRows stage feeding mixcolumn.
// Accepts one 128-bit state per valid/ready handshake, substitutes
// BYTES_PER_CYCLE bytes per cycle, then presents ShiftRows(SubBytes(state)).
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_data_i    128-bit state; byte k = 4*col + row at bits [8k+7:8k]
//   in_valid_i   input valid
//   in_ready_o   input ready (combinational from out_ready_i in DONE)
//   out_data_o   registered ShiftRows(SubBytes(input)), same packing
//   out_valid_o  registered output valid
//   out_ready_i  consumer ready
module sub_shift_stage #(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [127:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [127:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    localparam int unsigned NSLICE = 16 / BYTES_PER_CYCLE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    // FIPS-197 forward S-box
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [127:0]     work;
    logic [127:0]     out_reg;
    logic [127:0]     work_next_c;
    logic [3:0]       sel_idx;

    // ShiftRows: out[r][c] = in[r][(c+r) mod 4]
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[32*c + 8*r +: 8] = s[32*((c + r) % 4) + 8*r +: 8];
            end
        end
        return o;
    endfunction

    // Substitute the current slice; BYTES_PER_CYCLE S-box lookups muxed by cnt
    always_comb begin
        work_next_c = work;
        sel_idx     = '0;
        for (int j = 0; j < int'(BYTES_PER_CYCLE); j++) begin
            sel_idx = 4'(int'(cnt) * int'(BYTES_PER_CYCLE) + j);
            work_next_c[8*sel_idx +: 8] = SBOX[work[8*sel_idx +: 8]];
        end
    end

    // State, slice counter and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            work        <= '0;
            out_reg     <= '0;
            out_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        work  <= in_data_i;
                        cnt   <= '0;
                        state <= SUB;
                    end
                end
                SUB: begin
                    work <= work_next_c;
                    if (cnt == CNT_LAST) begin
                        out_reg     <= shift_rows(work_next_c);
                        out_valid_o <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        // Chain straight into the next block to skip IDLE
                        if (in_valid_i) begin
                            work  <= in_data_i;
                            cnt   <= '0;
                            state <= SUB;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_o <= 1'b0;
                end
            endcase
        end
    end

    assign out_data_o = out_reg;
    assign in_ready_o = (state == IDLE) | ((state == DONE) & out_ready_i);

endmodule
